// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with parallel load, synchronous clear,
// combinational terminal count, a registered wrap pulse and a sticky
// overflow flag. Arithmetic is modulo MODULUS, so q never reaches MODULUS
// even when MODULUS is smaller than 2**WIDTH.
module mod_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Highest legal count and the unit step, both sized to the register.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;

  logic at_top, at_bottom;

  assign at_top    = (q_q == MAX_VAL);
  assign at_bottom = (q_q == ZERO);

  // Next-state selection with priority clr > load > en; idle holds q.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    if (clr) begin
      q_d   = ZERO;
      ovf_d = 1'b0;
    end else if (load) begin
      // Out-of-range load values saturate at the top of the range.
      q_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          q_d    = ZERO;
          wrap_d = 1'b1;
          ovf_d  = 1'b1;
        end else begin
          q_d = q_q + ONE;
        end
      end else begin
        if (at_bottom) begin
          q_d    = MAX_VAL;
          wrap_d = 1'b1;
          ovf_d  = 1'b1;
        end else begin
          q_d = q_q - ONE;
        end
      end
    end
  end

  // State registers; reset clears count and flags without waiting for clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= ZERO;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  // Terminal count looks at the live enable and direction, zero latency.
  assign tc   = en & ((up & at_top) | (~up & at_bottom));
  assign q    = q_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three instances (modulus 10, 2 and 16)
// share one set of stimulus and are each compared every cycle against a
// modulo-arithmetic model, with hand-computed spot checks along the way.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up = 1'b1, load = 1'b0, clr = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] q_a, q_c;
  logic [0:0] q_b;
  logic       tc_a, tc_b, tc_c, wrap_a, wrap_b, wrap_c, ovf_a, ovf_b, ovf_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr(clr), .q(q_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a));

  mod_updown_counter #(.WIDTH(1), .MODULUS(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[0:0]),
    .clr(clr), .q(q_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b));

  mod_updown_counter #(.WIDTH(4), .MODULUS(16)) dut_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr(clr), .q(q_c), .tc(tc_c), .wrap(wrap_c), .ovf(ovf_c));

  // Model state per instance: modulus, load-value mask, count, wrap, ovf.
  int mm[3]   = '{10, 2, 16};
  int mask[3] = '{15, 1, 15};
  int mq[3]   = '{0, 0, 0};
  int mw[3]   = '{0, 0, 0};
  int mo[3]   = '{0, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain modulo arithmetic on integers.
  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        mq[i] = 0; mw[i] = 0; mo[i] = 0;
      end else if (clr) begin
        mq[i] = 0; mw[i] = 0; mo[i] = 0;
      end else if (load) begin
        int lv;
        lv = int'(load_val) & mask[i];
        mq[i] = (lv > mm[i] - 1) ? mm[i] - 1 : lv;
        mw[i] = 0;
      end else if (en) begin
        int nxt;
        nxt = up ? mq[i] + 1 : mq[i] - 1;
        mw[i] = (nxt == mm[i] || nxt == -1) ? 1 : 0;
        mq[i] = (nxt + mm[i]) % mm[i];
        if (mw[i] == 1) mo[i] = 1;
      end else begin
        mw[i] = 0;
      end
    end
  end

  function automatic int model_tc(input int i);
    return (en && ((up && mq[i] == mm[i] - 1) || (!up && mq[i] == 0))) ? 1 : 0;
  endfunction

  // Per-cycle comparison, mid-cycle away from the active edge.
  always @(negedge clk) begin
    chk("a.q", int'(q_a), mq[0]);  chk("a.tc", int'(tc_a), model_tc(0));
    chk("a.wrap", int'(wrap_a), mw[0]); chk("a.ovf", int'(ovf_a), mo[0]);
    chk("b.q", int'(q_b), mq[1]);  chk("b.tc", int'(tc_b), model_tc(1));
    chk("b.wrap", int'(wrap_b), mw[1]); chk("b.ovf", int'(ovf_b), mo[1]);
    chk("c.q", int'(q_c), mq[2]);  chk("c.tc", int'(tc_c), model_tc(2));
    chk("c.wrap", int'(wrap_c), mw[2]); chk("c.ovf", int'(ovf_c), mo[2]);
  end

  // Advance n edges; inputs change 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset held for two edges with counting requested.
    en = 1'b1; up = 1'b1;
    step(2);
    chk("rst.q", int'(q_a), 0);
    chk("rst.ovf", int'(ovf_a), 0);
    rst = 1'b1;

    // Count up 0..9 then wrap.
    step(9);
    chk("up9.q", int'(q_a), 9);
    chk("up9.tc", int'(tc_a), 1);
    chk("up9.c.q", int'(q_c), 9);
    step(1);
    chk("wrap.q", int'(q_a), 0);
    chk("wrap.pulse", int'(wrap_a), 1);
    chk("wrap.ovf", int'(ovf_a), 1);
    chk("wrap.c.q", int'(q_c), 10);
    step(1);
    chk("wrap.end", int'(wrap_a), 0);
    chk("wrap.ovf_held", int'(ovf_a), 1);
    chk("wrap.q1", int'(q_a), 1);

    // Load 4, then count down through the 0 -> 9 wrap.
    en = 1'b0; load = 1'b1; load_val = 4'd4;
    step(1);
    chk("load4.q", int'(q_a), 4);
    chk("load4.wrap", int'(wrap_a), 0);
    load = 1'b0; en = 1'b1; up = 1'b0;
    step(4);
    chk("down0.q", int'(q_a), 0);
    chk("down0.tc", int'(tc_a), 1);
    step(1);
    chk("down.wrapq", int'(q_a), 9);
    chk("down.wrap", int'(wrap_a), 1);

    // Out-of-range load clamps and beats en.
    load = 1'b1; load_val = 4'd13; up = 1'b1;
    step(1);
    chk("clamp.q", int'(q_a), 9);
    chk("clamp.wrap", int'(wrap_a), 0);
    chk("clamp.ovf", int'(ovf_a), 1);
    chk("clamp.c.q", int'(q_c), 13);

    // clr beats load and en, and suppresses the coincident wrap.
    clr = 1'b1;
    step(1);
    chk("clr.q", int'(q_a), 0);
    chk("clr.ovf", int'(ovf_a), 0);
    chk("clr.wrap", int'(wrap_a), 0);
    clr = 1'b0; load = 1'b0;

    // Count to 6, then reset asynchronously between edges.
    step(6);
    chk("pre_rst.q", int'(q_a), 6);
    #2 rst = 1'b0;
    #1 chk("async.q", int'(q_a), 0);
    step(1);
    rst = 1'b1;
    step(1);
    chk("resume.q", int'(q_a), 1);

    // Direction reversal takes effect on the same edge.
    step(1);
    up = 1'b0;
    step(1);
    chk("dir.q", int'(q_a), 1);

    // Full-range instance: natural binary wrap at 15 -> 0.
    en = 1'b0; load = 1'b1; load_val = 4'd15;
    step(1);
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1 chk("c.tc15", int'(tc_c), 1);
    step(1);
    chk("c.wrapq", int'(q_c), 0);
    chk("c.wrap", int'(wrap_c), 1);

    // Mixed directed/pseudo-random phase checked by the model.
    for (int k = 0; k < 200; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      en       = (r % 4) != 0;
      up       = (r % 7) < 4;
      load     = (r % 13) == 0;
      clr      = (r % 31) == 0;
      load_val = 4'($urandom_range(0, 15));
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
